// File: rtl/jk_ff_bank.sv
// WIDTH-bit bank of flip-flops with runtime-selectable JK/SR/D/T behaviour,
// synchronous load, sticky illegal-SR flags and a saturating change counter.
module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] sr_err,
    output logic             sr_err_any,
    output logic             chg,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [1:0]       MODE_JK = 2'b00;
    localparam logic [1:0]       MODE_SR = 2'b01;
    localparam logic [1:0]       MODE_D  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] qb_reg;
    logic [WIDTH-1:0] upd_q;
    logic [WIDTH-1:0] new_err;
    logic [WIDTH-1:0] sr_err_reg, sr_err_next;
    logic             chg_reg, chg_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_next;
            logic bit_err;

            always_comb begin
                bit_next = q_reg[gi];
                bit_err  = 1'b0;
                case (mode)
                    MODE_JK: begin
                        case ({j[gi], k[gi]})
                            2'b01:   bit_next = 1'b0;
                            2'b10:   bit_next = 1'b1;
                            2'b11:   bit_next = ~q_reg[gi];
                            default: bit_next = q_reg[gi];
                        endcase
                    end
                    MODE_SR: begin
                        // S=R=1 keeps the state and raises the error flag instead
                        case ({j[gi], k[gi]})
                            2'b01:   bit_next = 1'b0;
                            2'b10:   bit_next = 1'b1;
                            2'b11:   bit_err  = 1'b1;
                            default: bit_next = q_reg[gi];
                        endcase
                    end
                    MODE_D:  bit_next = j[gi];
                    default: bit_next = q_reg[gi] ^ j[gi];
                endcase
            end

            assign upd_q[gi]   = bit_next;
            assign new_err[gi] = bit_err;
        end
    endgenerate

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            q_next = upd_q;
        end
        // Errors only count on real update edges; a coincident clear loses to a new error
        sr_err_next = (err_clr ? '0 : sr_err_reg) | ((en && !load) ? new_err : '0);
        chg_next    = (q_next != q_reg);
        cnt_next    = cnt_reg;
        if (chg_next && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg      <= RST_VAL;
            qb_reg     <= ~RST_VAL;
            sr_err_reg <= '0;
            chg_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            q_reg      <= q_next;
            qb_reg     <= ~q_next;
            sr_err_reg <= sr_err_next;
            chg_reg    <= chg_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign q          = q_reg;
    assign qb         = qb_reg;
    assign sr_err     = sr_err_reg;
    assign sr_err_any = |sr_err_reg;
    assign chg        = chg_reg;
    assign chg_cnt    = cnt_reg;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Self-checking bench for jk_ff_bank: directed scenarios plus randomized traffic
// against a word-level behavioural model; two instances cover RST_VAL and a 3-bit counter.
module tb_jk_ff_bank;

    logic       clk = 1'b0;
    logic       rst, en, load, err_clr;
    logic [1:0] mode;
    logic [7:0] j, k, load_val;

    logic [7:0] q1, qb1, err1;
    logic       any1, chg1;
    logic [7:0] cnt1;
    logic [7:0] q2, qb2, err2;
    logic       any2, chg2;
    logic [2:0] cnt2;

    int total = 0;
    int bad   = 0;

    // model state: index 0 = RST_VAL A5 / 8-bit counter, index 1 = RST_VAL 0 / 3-bit counter
    logic [7:0] mq [2];
    logic       mchg [2];
    int         mcnt [2];
    logic [7:0] merr;
    int         cmax [2] = '{255, 7};

    always #5 clk = ~clk;

    jk_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_val(load_val), .err_clr(err_clr),
        .q(q1), .qb(qb1), .sr_err(err1), .sr_err_any(any1),
        .chg(chg1), .chg_cnt(cnt1)
    );

    jk_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_val(load_val), .err_clr(err_clr),
        .q(q2), .qb(qb2), .sr_err(err2), .sr_err_any(any2),
        .chg(chg2), .chg_cnt(cnt2)
    );

    // Flip-flop characteristic equations applied to whole words
    function automatic logic [7:0] ff_eq(input logic [7:0] cq, input logic [1:0] md,
                                         input logic [7:0] jj, input logic [7:0] kk);
        case (md)
            2'd0:    return (jj & ~cq) | (~kk & cq);
            2'd1:    return (jj & ~kk) | (cq & ~(jj ^ kk));
            2'd2:    return jj;
            default: return cq ^ jj;
        endcase
    endfunction

    // Advance the model with the current inputs, clock once, sample 1 time unit later
    task automatic tick();
        logic [7:0] nq;
        if (rst) begin
            mq[0] = 8'hA5;
            mq[1] = 8'h00;
            merr  = 8'h00;
            for (int i = 0; i < 2; i++) begin
                mchg[i] = 1'b0;
                mcnt[i] = 0;
            end
        end else begin
            merr = (err_clr ? 8'h00 : merr) | ((en && !load && mode == 2'd1) ? (j & k) : 8'h00);
            for (int i = 0; i < 2; i++) begin
                nq = load ? load_val : (en ? ff_eq(mq[i], mode, j, k) : mq[i]);
                mchg[i] = (nq != mq[i]);
                if (mchg[i] && mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
                mq[i] = nq;
            end
        end
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b ld=%b en=%b mode=%0d j=%h k=%h clr=%b | q=%h qb=%h err=%h chg=%b cnt=%0d cnt3=%0d",
                 $time, rst, load, en, mode, j, k, err_clr, q1, qb1, err1, chg1, cnt1, cnt2);
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; load = 0; err_clr = 0; mode = 0;
        j = 0; k = 0; load_val = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        total++; if (q1 !== 8'hA5) begin bad++; $display("FAIL reset_q got=%h exp=%h", q1, 8'hA5); end
        total++; if (qb1 !== 8'h5A) begin bad++; $display("FAIL reset_qb got=%h exp=%h", qb1, 8'h5A); end
        total++; if (err1 !== 8'h00 || any1 !== 1'b0) begin bad++; $display("FAIL reset_err got=%h/%b exp=00/0", err1, any1); end
        total++; if (chg1 !== 1'b0 || cnt1 !== 8'd0) begin bad++; $display("FAIL reset_chg got=%b/%0d exp=0/0", chg1, cnt1); end
        total++; if (q2 !== 8'h00 || qb2 !== 8'hFF) begin bad++; $display("FAIL reset_q2 got=%h/%h exp=00/ff", q2, qb2); end
        for (int c = 0; c < 5; c++) begin
            en = 0; mode = 2'($urandom); j = 8'($urandom); k = 8'($urandom);
            tick();
            total++; if (q1 !== 8'hA5 || qb1 !== 8'h5A) begin bad++; $display("FAIL hold_q got=%h/%h exp=a5/5a", q1, qb1); end
            total++; if (chg1 !== 1'b0 || cnt1 !== 8'd0) begin bad++; $display("FAIL hold_chg got=%b/%0d exp=0/0", chg1, cnt1); end
        end
    endtask

    task automatic test_jk();
        idle_inputs();
        rst = 1; tick(); rst = 0;
        en = 1; mode = 2'd0; j = 8'hF0; k = 8'h0F;
        tick();
        total++; if (q1 !== 8'hF0 || q2 !== 8'hF0) begin bad++; $display("FAIL jk_setclr got=%h/%h exp=f0", q1, q2); end
        j = 8'hFF; k = 8'hFF;
        tick();
        total++; if (q1 !== 8'h0F || qb1 !== 8'hF0) begin bad++; $display("FAIL jk_toggle got=%h/%h exp=0f/f0", q1, qb1); end
        total++; if (chg2 !== 1'b1 || cnt2 !== 3'd2) begin bad++; $display("FAIL jk_toggle_cnt got=%b/%0d exp=1/2", chg2, cnt2); end
        j = 8'h00; k = 8'h00;
        tick();
        total++; if (q1 !== 8'h0F) begin bad++; $display("FAIL jk_hold got=%h exp=0f", q1); end
        total++; if (chg2 !== 1'b0 || cnt2 !== 3'd2) begin bad++; $display("FAIL jk_hold_cnt got=%b/%0d exp=0/2", chg2, cnt2); end
    endtask

    task automatic test_sr();
        idle_inputs();
        load = 1; load_val = 8'h3C;
        tick();
        load = 0; en = 1; mode = 2'd1; j = 8'h81; k = 8'h81;
        tick();
        total++; if (q1 !== 8'h3C) begin bad++; $display("FAIL sr_illegal_q got=%h exp=3c", q1); end
        total++; if (err1 !== 8'h81 || any1 !== 1'b1) begin bad++; $display("FAIL sr_illegal_err got=%h/%b exp=81/1", err1, any1); end
        err_clr = 1; j = 8'h02; k = 8'h02;
        tick();
        total++; if (err1 !== 8'h02) begin bad++; $display("FAIL sr_clr_new got=%h exp=02", err1); end
        j = 8'h00; k = 8'h00;
        tick();
        total++; if (err1 !== 8'h00 || any1 !== 1'b0) begin bad++; $display("FAIL sr_clr got=%h/%b exp=00/0", err1, any1); end
    endtask

    task automatic test_d_t();
        idle_inputs();
        en = 1; mode = 2'd2; j = 8'h55;
        tick();
        total++; if (q1 !== 8'h55 || qb1 !== 8'hAA) begin bad++; $display("FAIL d_mode got=%h/%h exp=55/aa", q1, qb1); end
        mode = 2'd3; j = 8'hFF;
        tick();
        total++; if (q1 !== 8'hAA || qb1 !== 8'h55) begin bad++; $display("FAIL t_mode got=%h/%h exp=aa/55", q1, qb1); end
    endtask

    task automatic test_priority();
        idle_inputs();
        load = 1; load_val = 8'h12; en = 1; mode = 2'd0; j = 8'hFF; k = 8'hFF;
        tick();
        total++; if (q1 !== 8'h12 || qb1 !== 8'hED) begin bad++; $display("FAIL load_over_en got=%h/%h exp=12/ed", q1, qb1); end
        rst = 1;
        tick();
        rst = 0; load = 0;
        total++; if (q1 !== 8'hA5 || cnt1 !== 8'd0 || chg1 !== 1'b0) begin
            bad++; $display("FAIL rst_over_load got=%h/%0d/%b exp=a5/0/0", q1, cnt1, chg1);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        rst = 1; tick(); rst = 0;
        en = 1; mode = 2'd3; j = 8'h01;
        for (int c = 1; c <= 10; c++) begin
            tick();
            total++; if (cnt2 !== 3'((c < 7) ? c : 7)) begin bad++; $display("FAIL sat_cnt cycle=%0d got=%0d exp=%0d", c, cnt2, (c < 7) ? c : 7); end
            total++; if (chg2 !== 1'b1) begin bad++; $display("FAIL sat_chg cycle=%0d got=%b exp=1", c, chg2); end
            total++; if (cnt1 !== 8'(c)) begin bad++; $display("FAIL wide_cnt cycle=%0d got=%0d exp=%0d", c, cnt1, c); end
        end
    endtask

    task automatic test_random();
        logic [7:0] e0, e1;
        for (int c = 0; c < 300; c++) begin
            rst      = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            mode     = 2'($urandom);
            j        = 8'($urandom);
            k        = 8'($urandom);
            load_val = 8'($urandom);
            err_clr  = en && !load && ($urandom_range(0, 3) == 0);
            tick();
            e0 = 8'(mcnt[0]);
            e1 = 8'(mcnt[1]);
            total++; if (q1 !== mq[0]) begin bad++; $display("FAIL rnd_q got=%h exp=%h", q1, mq[0]); end
            total++; if (qb1 !== ~mq[0]) begin bad++; $display("FAIL rnd_qb got=%h exp=%h", qb1, ~mq[0]); end
            total++; if (err1 !== merr || any1 !== (merr != 8'h00)) begin bad++; $display("FAIL rnd_err got=%h/%b exp=%h", err1, any1, merr); end
            total++; if (chg1 !== mchg[0] || cnt1 !== e0) begin bad++; $display("FAIL rnd_chg got=%b/%0d exp=%b/%0d", chg1, cnt1, mchg[0], e0); end
            total++; if (q2 !== mq[1] || qb2 !== ~mq[1]) begin bad++; $display("FAIL rnd_q2 got=%h/%h exp=%h", q2, qb2, mq[1]); end
            total++; if (chg2 !== mchg[1] || cnt2 !== e1[2:0]) begin bad++; $display("FAIL rnd_cnt2 got=%b/%0d exp=%b/%0d", chg2, cnt2, mchg[1], e1); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_jk();
        test_sr();
        test_d_t();
        test_priority();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
